// File: rtl/serializer_pkg.sv
// Shared types and width helpers for the word serializer and its matching deserializer.
// Per-instance constants are derived inside each module from these helpers.
package serializer_pkg;

   typedef enum logic {
      S_IDLE,
      S_SERIAL
   } state_t;

   function automatic int ratio_of(input int in_w, input int out_w);
      return in_w / out_w;
   endfunction

   // A single-beat word still needs a 1-bit counter so the ports stay legal.
   function automatic int cnt_width(input int ratio);
      return (ratio > 1) ? $clog2(ratio) : 1;
   endfunction

   function automatic bit widths_ok(input int in_w, input int out_w);
      return (out_w > 0) && (out_w <= in_w) && ((in_w % out_w) == 0);
   endfunction

endpackage

// File: rtl/slice_mux.sv
// Counter-indexed slice select of a wide word, first slice chosen by LSB_FIRST.
module slice_mux
   import serializer_pkg::*;
#(
   parameter int IN_WIDTH  = 32,
   parameter int OUT_WIDTH = 8,
   parameter bit LSB_FIRST = 1'b1,
   parameter int CNT_W     = 2
) (
   input  logic [IN_WIDTH-1:0]  word,
   input  logic [CNT_W-1:0]     sel,
   output logic [OUT_WIDTH-1:0] slice
);

   localparam int RATIO = ratio_of(IN_WIDTH, OUT_WIDTH);

   // NOTE: every always_comb output gets a default before any branch; a path
   // that leaves it unassigned would infer a latch.
   always_comb begin
      slice = '0;
      for (int k = 0; k < RATIO; k++) begin
         if (sel == CNT_W'(k)) begin
            slice = word[(LSB_FIRST ? k : (RATIO - 1 - k)) * OUT_WIDTH +: OUT_WIDTH];
         end
      end
   end

endmodule

// File: rtl/word_serializer.sv
// Pops one wide word from a FIFO (EMPTY_N/D_OUT/DEQ style) and emits it as
// IN_WIDTH/OUT_WIDTH narrow beats on a valid/ready output with a last flag.
module word_serializer
   import serializer_pkg::*;
#(
   parameter int IN_WIDTH  = 32,
   parameter int OUT_WIDTH = 8,
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 CLR,
   input  logic [IN_WIDTH-1:0]  D_IN,
   input  logic                 EMPTY_N,
   output logic                 DEQ,
   output logic [OUT_WIDTH-1:0] out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 out_last,
   output logic                 busy
);

   localparam int              RATIO    = ratio_of(IN_WIDTH, OUT_WIDTH);
   localparam int              CNT_W    = cnt_width(RATIO);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATIO - 1);

   if (!widths_ok(IN_WIDTH, OUT_WIDTH)) begin : g_bad_widths
      $error("word_serializer: IN_WIDTH must be a positive multiple of OUT_WIDTH");
   end

   state_t              state, state_nxt;
   logic [CNT_W-1:0]    cnt, cnt_nxt;
   logic [IN_WIDTH-1:0] hold, hold_nxt;
   logic                at_last;
   logic                accept;

   assign out_valid = (state == S_SERIAL);
   assign busy      = out_valid;
   assign at_last   = (cnt == CNT_LAST);
   assign out_last  = out_valid & at_last;
   assign accept    = out_valid & out_ready;

   // RST is folded in combinationally so the FIFO is never popped during reset,
   // and a word in its last beat hands over to the next word with no bubble.
   assign DEQ = RST & ~CLR & EMPTY_N & (~out_valid | (out_ready & out_last));

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      hold_nxt  = hold;
      if (CLR) begin
         state_nxt = S_IDLE;
         cnt_nxt   = '0;
      end else if (DEQ) begin
         hold_nxt  = D_IN;
         cnt_nxt   = '0;
         state_nxt = S_SERIAL;
      end else if (accept) begin
         if (at_last) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
         end else begin
            cnt_nxt = cnt + CNT_W'(1);
         end
      end
   end

   // NOTE: state registers use non-blocking assignments only, so every flop
   // samples pre-edge values regardless of process ordering.
   // NOTE: the hold register is reset as well, so out_data reads zero out of reset.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state <= S_IDLE;
         cnt   <= '0;
         hold  <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         hold  <= hold_nxt;
      end
   end

   slice_mux #(
      .IN_WIDTH (IN_WIDTH),
      .OUT_WIDTH(OUT_WIDTH),
      .LSB_FIRST(LSB_FIRST),
      .CNT_W    (CNT_W)
   ) u_slice_mux (
      .word (hold),
      .sel  (cnt),
      .slice(out_data)
   );

endmodule

// File: tb/tb_word_serializer.sv
// Scoreboard bench for word_serializer: LSB-first 32/8, MSB-first 32/8 and 8/8 instances,
// fed from a queue-modelled FIFO, exercised one at a time.
module tb_word_serializer;

   typedef struct {
      logic [7:0] data;
      logic       last;
   } beat_t;

   logic        CLK;
   logic        RST;

   logic        a_clr, a_empty_n, a_deq, a_valid, a_ready, a_last, a_busy;
   logic [31:0] a_d_in;
   logic [7:0]  a_data;
   logic        b_clr, b_empty_n, b_deq, b_valid, b_ready, b_last, b_busy;
   logic [31:0] b_d_in;
   logic [7:0]  b_data;
   logic        c_clr, c_empty_n, c_deq, c_valid, c_ready, c_last, c_busy;
   logic [7:0]  c_d_in;
   logic [7:0]  c_data;

   logic [31:0] fifo[$];
   beat_t       sb[$];
   int          cur;
   logic        g_ready, g_clr;
   logic        s_deq, s_valid, s_last, s_busy, s_ready, s_empty;
   logic [7:0]  s_data;
   int          checks, errors;

   word_serializer #(.IN_WIDTH(32), .OUT_WIDTH(8), .LSB_FIRST(1'b1)) u_lsb (
      .CLK(CLK), .RST(RST), .CLR(a_clr), .D_IN(a_d_in), .EMPTY_N(a_empty_n), .DEQ(a_deq),
      .out_data(a_data), .out_valid(a_valid), .out_ready(a_ready), .out_last(a_last), .busy(a_busy));

   word_serializer #(.IN_WIDTH(32), .OUT_WIDTH(8), .LSB_FIRST(1'b0)) u_msb (
      .CLK(CLK), .RST(RST), .CLR(b_clr), .D_IN(b_d_in), .EMPTY_N(b_empty_n), .DEQ(b_deq),
      .out_data(b_data), .out_valid(b_valid), .out_ready(b_ready), .out_last(b_last), .busy(b_busy));

   word_serializer #(.IN_WIDTH(8), .OUT_WIDTH(8), .LSB_FIRST(1'b1)) u_r1 (
      .CLK(CLK), .RST(RST), .CLR(c_clr), .D_IN(c_d_in), .EMPTY_N(c_empty_n), .DEQ(c_deq),
      .out_data(c_data), .out_valid(c_valid), .out_ready(c_ready), .out_last(c_last), .busy(c_busy));

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   // Expected beats for the active instance, derived from the word alone.
   task automatic push_word(input logic [31:0] word, input int keep);
      int    ratio;
      int    idx;
      beat_t b;
      ratio = (cur == 2) ? 1 : 4;
      fifo.push_back(word);
      for (int k = 0; k < ratio; k++) begin
         idx    = (cur == 1) ? (ratio - 1 - k) : k;
         b.data = word[idx*8 +: 8];
         b.last = (k == ratio - 1);
         if (k < keep) sb.push_back(b);
      end
   endtask

   task automatic apply_inputs();
      logic        have;
      logic [31:0] head;
      have = (fifo.size() > 0);
      head = have ? fifo[0] : 32'h0;
      a_clr = 1'b0; a_empty_n = 1'b0; a_d_in = 32'h0; a_ready = 1'b1;
      b_clr = 1'b0; b_empty_n = 1'b0; b_d_in = 32'h0; b_ready = 1'b1;
      c_clr = 1'b0; c_empty_n = 1'b0; c_d_in = 8'h0;  c_ready = 1'b1;
      case (cur)
         0:       begin a_clr = g_clr; a_empty_n = have; a_d_in = head;      a_ready = g_ready; end
         1:       begin b_clr = g_clr; b_empty_n = have; b_d_in = head;      b_ready = g_ready; end
         default: begin c_clr = g_clr; c_empty_n = have; c_d_in = head[7:0]; c_ready = g_ready; end
      endcase
   endtask

   task automatic sample();
      case (cur)
         0:       begin s_deq = a_deq; s_valid = a_valid; s_last = a_last; s_busy = a_busy; s_data = a_data; s_ready = a_ready; s_empty = ~a_empty_n; end
         1:       begin s_deq = b_deq; s_valid = b_valid; s_last = b_last; s_busy = b_busy; s_data = b_data; s_ready = b_ready; s_empty = ~b_empty_n; end
         default: begin s_deq = c_deq; s_valid = c_valid; s_last = c_last; s_busy = c_busy; s_data = c_data; s_ready = c_ready; s_empty = ~c_empty_n; end
      endcase
   endtask

   // One clock: drive, sample on the falling edge, score any handshake, pop the FIFO model.
   task automatic step();
      beat_t exp_b;
      logic  pop;
      apply_inputs();
      @(negedge CLK);
      sample();
      checks++;
      if (s_busy !== s_valid) begin
         errors++;
         $display("FAIL busy_eq_valid: got busy=%b expected %b", s_busy, s_valid);
      end
      checks++;
      if (s_deq === 1'b1 && s_empty === 1'b1) begin
         errors++;
         $display("FAIL deq_when_empty: got DEQ=1 expected 0 (dut %0d)", cur);
      end
      if (s_valid === 1'b1 && s_ready === 1'b1) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_beat: got data=%h last=%b expected no beat", s_data, s_last);
         end else begin
            exp_b = sb.pop_front();
            if (s_data !== exp_b.data || s_last !== exp_b.last) begin
               errors++;
               $display("FAIL beat: got data=%h last=%b expected data=%h last=%b (dut %0d)",
                        s_data, s_last, exp_b.data, exp_b.last, cur);
            end
         end
      end
      pop = s_deq;
      @(posedge CLK);
      #1;
      if (pop === 1'b1 && fifo.size() > 0) void'(fifo.pop_front());
   endtask

   // mode 0: always ready, 1: random ready, 2: alternating ready
   task automatic drain(input string name, input int mode);
      int n;
      n = 0;
      while ((sb.size() != 0 || fifo.size() != 0) && n < 300) begin
         case (mode)
            0:       g_ready = 1'b1;
            1:       g_ready = 1'($urandom_range(0, 1));
            default: g_ready = n[0];
         endcase
         step();
         n++;
      end
      checks++;
      if (sb.size() != 0 || fifo.size() != 0) begin
         errors++;
         $display("FAIL %s_timeout: got %0d beats pending expected 0", name, sb.size());
         sb.delete();
         fifo.delete();
      end
      g_ready = 1'b1;
      step();
      checks++;
      if (s_valid !== 1'b0) begin
         errors++;
         $display("FAIL %s_idle: got out_valid=%b expected 0", name, s_valid);
      end
   endtask

   task automatic test_reset();
      cur = 0; g_ready = 1'b1; g_clr = 1'b0;
      RST = 1'b0;
      push_word(32'h55AA33CC, 4);
      repeat (3) begin
         step();
         checks++;
         if (s_deq !== 1'b0) begin
            errors++;
            $display("FAIL reset_deq: got %b expected 0", s_deq);
         end
         checks++;
         if (s_valid !== 1'b0 || s_last !== 1'b0 || s_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b last=%b data=%h expected 0 0 00", s_valid, s_last, s_data);
         end
      end
      RST = 1'b1;
      step();
      checks++;
      if (s_deq !== 1'b1) begin
         errors++;
         $display("FAIL reset_first_deq: got %b expected 1", s_deq);
      end
      step();
      checks++;
      if (s_valid !== 1'b1) begin
         errors++;
         $display("FAIL reset_first_valid: got %b expected 1", s_valid);
      end
      drain("reset", 0);
   endtask

   task automatic test_single_word();
      cur = 0; g_ready = 1'b1;
      push_word(32'hA1B2C3D4, 4);
      step();
      checks++;
      if (s_deq !== 1'b1 || s_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_load: got deq=%b valid=%b expected 1 0", s_deq, s_valid);
      end
      for (int i = 0; i < 4; i++) begin
         step();
         checks++;
         if (s_valid !== 1'b1 || s_last !== (i == 3)) begin
            errors++;
            $display("FAIL single_beat%0d: got valid=%b last=%b expected 1 %b", i, s_valid, s_last, (i == 3));
         end
      end
      step();
      checks++;
      if (s_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_end: got valid=%b expected 0", s_valid);
      end
   endtask

   task automatic test_back_to_back();
      cur = 0; g_ready = 1'b1;
      push_word(32'h03020100, 4);
      push_word(32'h07060504, 4);
      step();
      for (int i = 0; i < 8; i++) begin
         step();
         checks++;
         if (s_valid !== 1'b1 || s_deq !== (i == 3)) begin
            errors++;
            $display("FAIL b2b_beat%0d: got valid=%b deq=%b expected 1 %b", i, s_valid, s_deq, (i == 3));
         end
      end
      step();
      checks++;
      if (s_valid !== 1'b0) begin
         errors++;
         $display("FAIL b2b_end: got valid=%b expected 0", s_valid);
      end
   endtask

   task automatic test_stall();
      cur = 1; g_ready = 1'b1;
      push_word(32'h11223344, 4);
      push_word(32'hCAFEF00D, 4);
      step();
      step();
      step();
      g_ready = 1'b0;
      repeat (5) begin
         step();
         checks++;
         if (s_valid !== 1'b1 || s_data !== 8'h33 || s_last !== 1'b0 || s_deq !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold: got valid=%b data=%h last=%b deq=%b expected 1 33 0 0",
                     s_valid, s_data, s_last, s_deq);
         end
      end
      g_ready = 1'b1;
      step();
      checks++;
      if (s_data !== 8'h33 || s_deq !== 1'b0) begin
         errors++;
         $display("FAIL stall_resume: got data=%h deq=%b expected 33 0", s_data, s_deq);
      end
      step();
      checks++;
      if (s_data !== 8'h44 || s_last !== 1'b1 || s_deq !== 1'b1) begin
         errors++;
         $display("FAIL stall_last: got data=%h last=%b deq=%b expected 44 1 1", s_data, s_last, s_deq);
      end
      drain("stall", 0);
   endtask

   task automatic test_clr();
      cur = 0; g_ready = 1'b1;
      push_word(32'hDEADBEEF, 2);
      push_word(32'h12345678, 4);
      step();
      step();
      step();
      g_ready = 1'b0;
      g_clr   = 1'b1;
      step();
      checks++;
      if (s_deq !== 1'b0) begin
         errors++;
         $display("FAIL clr_deq: got %b expected 0", s_deq);
      end
      g_clr   = 1'b0;
      g_ready = 1'b1;
      step();
      checks++;
      if (s_valid !== 1'b0 || s_deq !== 1'b1) begin
         errors++;
         $display("FAIL clr_flush: got valid=%b deq=%b expected 0 1", s_valid, s_deq);
      end
      step();
      checks++;
      if (s_valid !== 1'b1 || s_data !== 8'h78) begin
         errors++;
         $display("FAIL clr_restart: got valid=%b data=%h expected 1 78", s_valid, s_data);
      end
      drain("clr", 0);
   endtask

   task automatic test_ratio1();
      cur = 2; g_ready = 1'b1;
      for (int i = 0; i < 5; i++) push_word(32'h10 + i, 1);
      step();
      for (int i = 0; i < 5; i++) begin
         step();
         checks++;
         if (s_valid !== 1'b1 || s_last !== 1'b1) begin
            errors++;
            $display("FAIL ratio1_beat%0d: got valid=%b last=%b expected 1 1", i, s_valid, s_last);
         end
      end
      step();
      checks++;
      if (s_valid !== 1'b0) begin
         errors++;
         $display("FAIL ratio1_end: got valid=%b expected 0", s_valid);
      end
      for (int i = 0; i < 6; i++) push_word(32'hE0 + i, 1);
      drain("ratio1_toggle", 2);
   endtask

   task automatic test_random_ready();
      for (int d = 0; d < 2; d++) begin
         cur = d;
         for (int i = 0; i < 4; i++) push_word($urandom, 4);
         drain("random_ready", 1);
      end
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      cur     = 0;
      g_ready = 1'b1;
      g_clr   = 1'b0;
      RST     = 1'b1;
      apply_inputs();
      #1 RST  = 1'b0;
      test_reset();
      test_single_word();
      test_back_to_back();
      test_stall();
      test_clr();
      test_ratio1();
      test_random_ready();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
